// File: rtl/flit_injector_if.sv
// Core-side request/payload and link-side flit signals of the flit injector.
// master = injector side, slave = core/link side.
interface flit_injector_if #(
  parameter int unsigned LENW  = 4,
  parameter int unsigned NVCH  = 2,
  parameter int unsigned DATAW = 32,
  parameter int unsigned DSTW  = 8
);
  localparam int unsigned VCW = (NVCH > 1) ? $clog2(NVCH) : 1;

  logic             hreq;
  logic [DSTW-1:0]  hdst;
  logic [LENW-1:0]  hlen;
  logic             hack;
  logic [DATAW-1:0] pdata;
  logic             pvalid;
  logic             pready;
  logic [NVCH-1:0]  irdy;
  logic [NVCH-1:0]  ilck;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCW-1:0]   ovch;
  logic             busy;

  modport master (
    input  hreq, hdst, hlen, pdata, pvalid, irdy, ilck,
    output hack, pready, odata, ovalid, ovch, busy
  );

  modport slave (
    output hreq, hdst, hlen, pdata, pvalid, irdy, ilck,
    input  hack, pready, odata, ovalid, ovch, busy
  );
endinterface

// File: rtl/flit_injector.sv
// Transmit end of a router input-channel link: turns core requests into HEAD/BODY/TAIL/HEADTAIL flits.
// Optional flit/packet counters are built when INJ_STAT_EN is defined.
module flit_injector #(
  parameter int unsigned LENW  = 4,
  parameter int unsigned NVCH  = 2,
  parameter int unsigned DATAW = 32,
  parameter int unsigned DSTW  = 8
) (
  input  logic clk,
  input  logic rst_,
  flit_injector_if.master bus
`ifdef INJ_STAT_EN
  ,
  output logic [15:0] sent_flits,
  output logic [15:0] sent_pkts
`endif
);

  localparam int unsigned VCW      = (NVCH > 1) ? $clog2(NVCH) : 1;
  localparam int unsigned DST_LSB  = 8;
  localparam int unsigned TYPE_MSB = DATAW - 1;

  // Flit type field: bit1 = head, bit0 = tail
  localparam logic [1:0] TY_BODY     = 2'b00;
  localparam logic [1:0] TY_TAIL     = 2'b01;
  localparam logic [1:0] TY_HEAD     = 2'b10;
  localparam logic [1:0] TY_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, VCSEL, HEAD, BODY} state_t;

  state_t           state;
  logic [DSTW-1:0]  dst_r;
  logic [LENW-1:0]  cnt_r;
  logic [VCW-1:0]   vc_r;
  logic [VCW-1:0]   rr_ptr;

  logic             pick_ok;
  logic [VCW-1:0]   pick_vc;
  logic [VCW-1:0]   pick_idx;
  logic [VCW-1:0]   rr_next;
  logic             send_ok;
  logic             head_go;
  logic             body_xfer;
  logic             last_cnt;
  logic [1:0]       head_type;
  logic [1:0]       body_type;
  logic [DATAW-1:0] head_flit;
  logic [DATAW-1:0] body_flit;

  // Round-robin VC pick starting at rr_ptr; scanning backwards leaves the nearest eligible VC
  always_comb begin
    pick_ok  = 1'b0;
    pick_vc  = '0;
    pick_idx = '0;
    for (int i = int'(NVCH) - 1; i >= 0; i--) begin
      pick_idx = VCW'((int'(rr_ptr) + i) % int'(NVCH));
      if (bus.irdy[pick_idx] && !bus.ilck[pick_idx]) begin
        pick_ok = 1'b1;
        pick_vc = pick_idx;
      end
    end
  end

  assign rr_next   = VCW'((int'(pick_vc) + 1) % int'(NVCH));
  assign send_ok   = bus.irdy[vc_r];
  assign last_cnt  = (cnt_r == LENW'(1));
  assign head_go   = (state == HEAD) && send_ok;
  assign body_xfer = (state == BODY) && bus.pvalid && send_ok;
  assign head_type = (cnt_r == '0) ? TY_HEADTAIL : TY_HEAD;
  assign body_type = last_cnt ? TY_TAIL : TY_BODY;

  // Head carries only type, destination and its own VC; body keeps the payload except the type bits
  always_comb begin
    head_flit                        = '0;
    head_flit[TYPE_MSB -: 2]         = head_type;
    head_flit[DST_LSB +: DSTW]       = dst_r;
    head_flit[VCW-1:0]               = vc_r;
    body_flit                        = bus.pdata;
    body_flit[TYPE_MSB -: 2]         = body_type;
  end

  // pready follows the receiver same-cycle so a payload word is only taken when it can be sent
  assign bus.pready = (state == BODY) && send_ok;
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      dst_r      <= '0;
      cnt_r      <= '0;
      vc_r       <= '0;
      rr_ptr     <= '0;
      bus.hack   <= 1'b0;
      bus.ovalid <= 1'b0;
      bus.odata  <= '0;
      bus.ovch   <= '0;
    end else begin
      bus.hack   <= 1'b0;
      bus.ovalid <= 1'b0;
      bus.odata  <= '0;
      bus.ovch   <= '0;
      case (state)
        IDLE: begin
          if (bus.hreq) begin
            dst_r <= bus.hdst;
            cnt_r <= bus.hlen;
            state <= VCSEL;
          end
        end
        VCSEL: begin
          if (pick_ok) begin
            vc_r     <= pick_vc;
            rr_ptr   <= rr_next;
            bus.hack <= 1'b1;
            state    <= HEAD;
          end
        end
        HEAD: begin
          if (head_go) begin
            bus.ovalid <= 1'b1;
            bus.ovch   <= vc_r;
            bus.odata  <= head_flit;
            state      <= (cnt_r == '0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (body_xfer) begin
            bus.ovalid <= 1'b1;
            bus.ovch   <= vc_r;
            bus.odata  <= body_flit;
            cnt_r      <= cnt_r - LENW'(1);
            if (last_cnt) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INJ_STAT_EN
  logic flit_go;
  logic pkt_done;

  assign flit_go  = head_go || body_xfer;
  assign pkt_done = (head_go && (cnt_r == '0)) || (body_xfer && last_cnt);

  // Free-running wrap-around counters, updated on the same edge that registers the flit
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sent_flits <= '0;
      sent_pkts  <= '0;
    end else begin
      if (flit_go)  sent_flits <= sent_flits + 16'd1;
      if (pkt_done) sent_pkts  <= sent_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: table of packets with hand-computed flits plus
// hand sequences for VC lock stall and mid-packet reset (and counters with INJ_STAT_EN).
module tb_flit_injector;

  logic clk = 1'b0;
  logic rst_;

  flit_injector_if #(.LENW(4), .NVCH(2), .DATAW(32), .DSTW(8)) bus ();

`ifdef INJ_STAT_EN
  logic [15:0] sent_flits;
  logic [15:0] sent_pkts;
`endif

  flit_injector #(.LENW(4), .NVCH(2), .DATAW(32), .DSTW(8)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
`ifdef INJ_STAT_EN
    ,
    .sent_flits (sent_flits),
    .sent_pkts  (sent_pkts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       dst;
    logic [3:0]       len;
    logic [1:0]       irdy;
    int               stall;
    logic [0:0]       vc;
    logic [3:0][31:0] ef;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] pay[16];
  logic [31:0] cap_d[16];
  logic [0:0]  cap_v[16];
  int          cap_n, first_cyc, last_cyc, abort_n, stall_cycles;
  logic        zero_ok;
  int          nvec, nfail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] d, input logic [3:0] l, input logic [1:0] r,
                         input int s, input logic [0:0] v, input logic [31:0] f0, input logic [31:0] f1,
                         input logic [31:0] f2, input logic [31:0] f3);
    vecs[i].dst   = d;
    vecs[i].len   = l;
    vecs[i].irdy  = r;
    vecs[i].stall = s;
    vecs[i].vc    = v;
    vecs[i].ef[0] = f0;
    vecs[i].ef[1] = f1;
    vecs[i].ef[2] = f2;
    vecs[i].ef[3] = f3;
  endtask

  // Issue one packet and capture its flits; bounded by a cycle budget
  task automatic run_pkt(input logic [7:0] dst, input logic [3:0] len, input logic [1:0] rdy);
    int   cyc;
    int   pidx;
    logic pr_prev;
    cap_n = 0; first_cyc = -1; last_cyc = -1; zero_ok = 1'b1;
    pidx = 0; cyc = 0;
    @(negedge clk);
    bus.irdy = rdy; bus.hreq = 1'b1; bus.hdst = dst; bus.hlen = len; bus.pvalid = 1'b0;
    #1 pr_prev = 1'b0;
    while (cap_n < int'(len) + 1 && cap_n != abort_n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (pr_prev) pidx++;
      if (bus.hack) bus.hreq = 1'b0;
      if (bus.ovalid) begin
        cap_d[cap_n] = bus.odata;
        cap_v[cap_n] = bus.ovch;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        cap_n++;
      end else if (bus.odata != 32'h0 || bus.ovch != 1'b0) begin
        zero_ok = 1'b0;
      end
      if (cap_n == 2 && stall_cycles > 0) begin
        bus.irdy = 2'b00;
        stall_cycles--;
      end else begin
        bus.irdy = rdy;
      end
      if (pidx < int'(len)) begin
        bus.pvalid = 1'b1;
        bus.pdata  = pay[pidx];
      end else begin
        bus.pvalid = 1'b0;
      end
      #1 pr_prev = bus.pvalid && bus.pready;
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    stall_cycles = v.stall;
    abort_n = -1;
    run_pkt(v.dst, v.len, v.irdy);
    chk($sformatf("v%0d nflits", idx), 64'(cap_n), 64'(int'(v.len) + 1));
    for (int k = 0; k < cap_n && k < 4; k++) begin
      chk($sformatf("v%0d flit%0d data", idx, k), 64'(cap_d[k]), 64'(v.ef[2'(k)]));
      chk($sformatf("v%0d flit%0d vc", idx, k), 64'(cap_v[k]), 64'(v.vc));
    end
    chk($sformatf("v%0d latency", idx), 64'(first_cyc), 64'(3));
    chk($sformatf("v%0d span", idx), 64'(last_cyc - first_cyc), 64'(int'(v.len) + v.stall));
    chk($sformatf("v%0d idle_zero", idx), 64'(zero_ok), 64'(1));
  endtask

  initial begin
    int   cyc;
    logic hack_seen;
    logic found;
    nvec = 0; nfail = 0;
    abort_n = -1; stall_cycles = 0;
    rst_ = 1'b1;
    bus.hreq = 1'b0; bus.hdst = 8'h0; bus.hlen = 4'h0; bus.pdata = 32'h0; bus.pvalid = 1'b0;
    bus.irdy = 2'b00; bus.ilck = 2'b00;

    pay[0] = 32'hAAAA_0001;
    pay[1] = 32'hBBBB_0002;
    pay[2] = 32'hCCCC_0003;
    for (int k = 3; k < 16; k++) pay[k] = 32'hD000_0000 | 32'(k);

    //        idx dst    len irdy  stall vc  head          f1            f2            f3
    set_vec(0, 8'h5A, 4'd0, 2'b11, 0, 1'b0, 32'hC000_5A00, 32'h0,        32'h0,        32'h0);
    set_vec(1, 8'h3C, 4'd3, 2'b11, 0, 1'b1, 32'h8000_3C01, 32'h2AAA_0001, 32'h3BBB_0002, 32'h4CCC_0003);
    set_vec(2, 8'h01, 4'd1, 2'b10, 0, 1'b1, 32'h8000_0101, 32'h6AAA_0001, 32'h0,        32'h0);
    set_vec(3, 8'hFF, 4'd2, 2'b11, 0, 1'b0, 32'h8000_FF00, 32'h2AAA_0001, 32'h7BBB_0002, 32'h0);
    set_vec(4, 8'h80, 4'd0, 2'b01, 0, 1'b0, 32'hC000_8000, 32'h0,        32'h0,        32'h0);
    set_vec(5, 8'h77, 4'd3, 2'b11, 2, 1'b1, 32'h8000_7701, 32'h2AAA_0001, 32'h3BBB_0002, 32'h4CCC_0003);
    set_vec(6, 8'h22, 4'd2, 2'b11, 0, 1'b0, 32'h8000_2200, 32'h2AAA_0001, 32'h7BBB_0002, 32'h0);

    #1 rst_ = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ovalid", 64'(bus.ovalid), 64'(0));
    chk("reset odata",  64'(bus.odata),  64'(0));
    chk("reset ovch",   64'(bus.ovch),   64'(0));
    chk("reset hack",   64'(bus.hack),   64'(0));
    chk("reset pready", 64'(bus.pready), 64'(0));
    chk("reset busy",   64'(bus.busy),   64'(0));
    rst_ = 1'b1;

    for (int i = 0; i < 6; i++) apply_vec(i);

    // VC0 locked and VC1 not ready: must hold in VC selection until the lock clears
    @(negedge clk);
    bus.irdy = 2'b01; bus.ilck = 2'b01; bus.hreq = 1'b1; bus.hdst = 8'h42; bus.hlen = 4'd0;
    bus.pvalid = 1'b0;
    hack_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.hack) hack_seen = 1'b1;
    end
    chk("lock hold hack",   64'(hack_seen),  64'(0));
    chk("lock hold busy",   64'(bus.busy),   64'(1));
    chk("lock hold ovalid", 64'(bus.ovalid), 64'(0));
    bus.ilck = 2'b00;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (bus.hack) bus.hreq = 1'b0;
      if (bus.ovalid) begin
        found = 1'b1;
        chk("unlock flit data", 64'(bus.odata), 64'(32'hC000_4200));
        chk("unlock flit vc",   64'(bus.ovch),  64'(0));
      end
    end
    chk("unlock flit seen", 64'(found), 64'(1));

    // Reset while a 5-body packet is mid-BODY, with a flit currently on the link
    stall_cycles = 0;
    abort_n = 3;
    run_pkt(8'h55, 4'd5, 2'b11);
    chk("midrst reached", 64'(cap_n), 64'(3));
    bus.pvalid = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    chk("midrst ovalid", 64'(bus.ovalid), 64'(0));
    chk("midrst odata",  64'(bus.odata),  64'(0));
    chk("midrst ovch",   64'(bus.ovch),   64'(0));
    chk("midrst busy",   64'(bus.busy),   64'(0));
    chk("midrst pready", 64'(bus.pready), 64'(0));
    @(negedge clk);
    rst_ = 1'b1;
    abort_n = -1;
    apply_vec(6);

`ifdef INJ_STAT_EN
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk("stat reset flits", 64'(sent_flits), 64'(0));
    chk("stat reset pkts",  64'(sent_pkts),  64'(0));
    @(negedge clk);
    rst_ = 1'b1;
    run_pkt(8'h10, 4'd0, 2'b11);
    run_pkt(8'h11, 4'd1, 2'b11);
    run_pkt(8'h12, 4'd2, 2'b11);
    @(negedge clk);
    chk("stat flits", 64'(sent_flits), 64'(6));
    chk("stat pkts",  64'(sent_pkts),  64'(3));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
